// File: rtl/axis_sf_frame_buffer.sv
// axis_sf_frame_buffer
//   Store-and-forward frame buffer in front of the AXI4 bus master. Frames are
//   accepted with backpressure and held until the last beat arrives. Errored
//   (tuser on tlast) and oversize frames are dropped. Each good frame is then
//   replayed as one gap-free burst, because the bus master's stream input has
//   no tready.
//
//   Optional macro AXIS_SF_DROP_CNT_EN adds a saturating 32-bit drop counter
//   output (drop_cnt).
//
// Ports
//   M_AXI_ACLK, M_AXI_ARESETN   clock, asynchronous active-low reset
//   s_axis_*                    upstream frame input (tuser = error flag,
//                               tdest is sampled on the first beat)
//   bus_busy                    bus master cannot start a new frame
//   m_axis_*                    burst output (tuser = start-of-frame marker)
//   frame_avail                 at least one committed frame is queued
//   drop_cnt                    dropped-frame count (macro only)
module axis_sf_frame_buffer #(
   parameter int DATA_DEPTH      = 512,
   parameter int INFO_DEPTH      = 16,
   parameter int MAX_FRAME_BEATS = 256,
   parameter int DEST_WIDTH      = 3
) (
   input  logic                  M_AXI_ACLK,
   input  logic                  M_AXI_ARESETN,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [63:0]           s_axis_tdata,
   input  logic [7:0]            s_axis_tkeep,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   input  logic [DEST_WIDTH-1:0] s_axis_tdest,
   input  logic                  bus_busy,
   output logic                  m_axis_tvalid,
   output logic [63:0]           m_axis_tdata,
   output logic [7:0]            m_axis_tkeep,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   output logic [DEST_WIDTH-1:0] m_axis_tdest,
   output logic                  frame_avail
`ifdef AXIS_SF_DROP_CNT_EN
  ,output logic [31:0]           drop_cnt
`endif
);

   localparam int DAW = $clog2(DATA_DEPTH);
   localparam int IAW = $clog2(INFO_DEPTH);
   localparam int IEW = 9 + DEST_WIDTH;
   localparam logic [8:0] MAX_B = 9'(MAX_FRAME_BEATS);

   typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_SEND} state_e;

   logic [71:0]     data_mem [DATA_DEPTH];
   logic [IEW-1:0]  info_mem [INFO_DEPTH];
   logic [71:0]     rdata_q;

   // write side
   logic [DAW:0]            wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d;
   logic [IAW:0]            iw_ptr_q, iw_ptr_d;
   logic [8:0]              frame_beats_q, frame_beats_d;
   logic                    discard_q, discard_d;
   logic [DEST_WIDTH-1:0]   dest_q, dest_d, cur_dest;
   logic                    alive_q;
   logic                    mem_we, info_we, drop_inc, s_acc;

   // read side
   state_e                  state_q;
   logic [DAW:0]            rd_ptr_q;
   logic [IAW:0]            ir_ptr_q;
   logic [8:0]              beats_q, rd_left_q, out_idx_q;
   logic [DEST_WIDTH-1:0]   odest_q;
   logic                    pop, rd_en;
   logic [IEW-1:0]          desc;

   logic data_full, info_full, info_empty;

   assign data_full  = (wr_ptr_q[DAW] != rd_ptr_q[DAW]) &&
                       (wr_ptr_q[DAW-1:0] == rd_ptr_q[DAW-1:0]);
   assign info_full  = (iw_ptr_q[IAW] != ir_ptr_q[IAW]) &&
                       (iw_ptr_q[IAW-1:0] == ir_ptr_q[IAW-1:0]);
   assign info_empty = (iw_ptr_q == ir_ptr_q);
   assign frame_avail = !info_empty;

   // alive_q keeps tready low while reset is asserted; in DISCARD beats are
   // swallowed without touching either FIFO.
   assign s_axis_tready = alive_q && (discard_q || (!data_full && !info_full));
   assign s_acc    = s_axis_tvalid && s_axis_tready;
   assign cur_dest = (frame_beats_q == 9'd0) ? s_axis_tdest : dest_q;

   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      cmt_ptr_d     = cmt_ptr_q;
      iw_ptr_d      = iw_ptr_q;
      frame_beats_d = frame_beats_q;
      discard_d     = discard_q;
      dest_d        = dest_q;
      mem_we        = 1'b0;
      info_we       = 1'b0;
      drop_inc      = 1'b0;
      if (s_acc) begin
         if (discard_q) begin
            if (s_axis_tlast) discard_d = 1'b0;
         end else begin
            mem_we        = 1'b1;
            wr_ptr_d      = wr_ptr_q + 1'b1;
            frame_beats_d = frame_beats_q + 9'd1;
            dest_d        = cur_dest;
            if (s_axis_tlast) begin
               frame_beats_d = 9'd0;
               if (s_axis_tuser) begin
                  wr_ptr_d = cmt_ptr_q;
                  drop_inc = 1'b1;
               end else begin
                  info_we   = 1'b1;
                  iw_ptr_d  = iw_ptr_q + 1'b1;
                  cmt_ptr_d = wr_ptr_q + 1'b1;
               end
            end else if (frame_beats_q + 9'd1 == MAX_B) begin
               // hit the size limit with no tlast: drop what was written
               discard_d     = 1'b1;
               wr_ptr_d      = cmt_ptr_q;
               frame_beats_d = 9'd0;
               drop_inc      = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         wr_ptr_q      <= '0;
         cmt_ptr_q     <= '0;
         iw_ptr_q      <= '0;
         frame_beats_q <= '0;
         discard_q     <= 1'b0;
         dest_q        <= '0;
         alive_q       <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         cmt_ptr_q     <= cmt_ptr_d;
         iw_ptr_q      <= iw_ptr_d;
         frame_beats_q <= frame_beats_d;
         discard_q     <= discard_d;
         dest_q        <= dest_d;
         alive_q       <= 1'b1;
      end
   end

   // storage: no reset, pointers define what is valid
   always_ff @(posedge M_AXI_ACLK) begin
      if (mem_we)  data_mem[wr_ptr_q[DAW-1:0]] <= {s_axis_tkeep, s_axis_tdata};
      if (info_we) info_mem[iw_ptr_q[IAW-1:0]] <= {frame_beats_q + 9'd1, cur_dest};
      if (rd_en)   rdata_q <= data_mem[rd_ptr_q[DAW-1:0]];
   end

   assign desc  = info_mem[ir_ptr_q[IAW-1:0]];
   assign pop   = (state_q == ST_IDLE) && !info_empty && !bus_busy;
   // one read per cycle from the pop until every beat has been fetched
   assign rd_en = pop || ((state_q != ST_IDLE) && (rd_left_q != 9'd0));

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         state_q       <= ST_IDLE;
         rd_ptr_q      <= '0;
         ir_ptr_q      <= '0;
         beats_q       <= '0;
         rd_left_q     <= '0;
         out_idx_q     <= '0;
         odest_q       <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
         m_axis_tdest  <= '0;
      end else begin
         if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (pop) begin
                  ir_ptr_q  <= ir_ptr_q + 1'b1;
                  beats_q   <= desc[IEW-1:DEST_WIDTH];
                  odest_q   <= desc[DEST_WIDTH-1:0];
                  rd_left_q <= desc[IEW-1:DEST_WIDTH] - 9'd1;
                  state_q   <= ST_PRIME;
               end
            end
            ST_PRIME: begin
               if (rd_left_q != 9'd0) rd_left_q <= rd_left_q - 9'd1;
               m_axis_tvalid <= 1'b1;
               {m_axis_tkeep, m_axis_tdata} <= rdata_q;
               m_axis_tuser  <= 1'b1;
               m_axis_tlast  <= (beats_q == 9'd1);
               m_axis_tdest  <= odest_q;
               out_idx_q     <= 9'd1;
               state_q       <= ST_SEND;
            end
            ST_SEND: begin
               if (rd_left_q != 9'd0) rd_left_q <= rd_left_q - 9'd1;
               if (m_axis_tlast) begin
                  m_axis_tvalid <= 1'b0;
                  m_axis_tdata  <= '0;
                  m_axis_tkeep  <= '0;
                  m_axis_tlast  <= 1'b0;
                  m_axis_tuser  <= 1'b0;
                  m_axis_tdest  <= '0;
                  state_q       <= ST_IDLE;
               end else begin
                  {m_axis_tkeep, m_axis_tdata} <= rdata_q;
                  m_axis_tuser  <= 1'b0;
                  m_axis_tlast  <= (out_idx_q == beats_q - 9'd1);
                  out_idx_q     <= out_idx_q + 9'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef AXIS_SF_DROP_CNT_EN
   logic [31:0] drop_cnt_q;
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN)                       drop_cnt_q <= '0;
      else if (drop_inc && (drop_cnt_q != '1))  drop_cnt_q <= drop_cnt_q + 32'd1;
   end
   assign drop_cnt = drop_cnt_q;
`else
   logic drop_unused;
   assign drop_unused = drop_inc;
`endif

endmodule

// File: tb/tb_axis_sf_frame_buffer.sv
module tb_axis_sf_frame_buffer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [63:0] s_axis_tdata = '0;
   logic [7:0]  s_axis_tkeep = '0;
   logic        s_axis_tlast = 1'b0;
   logic        s_axis_tuser = 1'b0;
   logic [2:0]  s_axis_tdest = '0;
   logic        bus_busy = 1'b0;
   logic        m_axis_tvalid;
   logic [63:0] m_axis_tdata;
   logic [7:0]  m_axis_tkeep;
   logic        m_axis_tlast;
   logic        m_axis_tuser;
   logic [2:0]  m_axis_tdest;
   logic        frame_avail;
`ifdef AXIS_SF_DROP_CNT_EN
   logic [31:0] drop_cnt;
`endif

   always #5 clk = ~clk;

   axis_sf_frame_buffer dut (
      .M_AXI_ACLK    (clk),
      .M_AXI_ARESETN (rst_n),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tdest  (s_axis_tdest),
      .bus_busy      (bus_busy),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tdest  (m_axis_tdest),
      .frame_avail   (frame_avail)
`ifdef AXIS_SF_DROP_CNT_EN
     ,.drop_cnt      (drop_cnt)
`endif
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // captured output beats
   logic [63:0] cap_data [$];
   logic [7:0]  cap_keep [$];
   logic        cap_last [$];
   logic        cap_user [$];
   logic [2:0]  cap_dest [$];
   int          cap_cyc  [$];

   always @(negedge clk) begin
      if (m_axis_tvalid) begin
         cap_data.push_back(m_axis_tdata);
         cap_keep.push_back(m_axis_tkeep);
         cap_last.push_back(m_axis_tlast);
         cap_user.push_back(m_axis_tuser);
         cap_dest.push_back(m_axis_tdest);
         cap_cyc.push_back(cyc);
      end
   end

   task automatic cap_clear();
      cap_data.delete(); cap_keep.delete(); cap_last.delete();
      cap_user.delete(); cap_dest.delete(); cap_cyc.delete();
   endtask

   function automatic logic [63:0] bdata(input logic [7:0] base, input int i);
      return {24'hC0FFEE, base, 32'(i)};
   endfunction

   function automatic logic [7:0] bkeep(input int i);
      logic [7:0] k;
      k = 8'hFF;
      return k >> (i % 4);
   endfunction

   // Drives one frame; tdest is valid only on beat 0 (other beats carry the
   // complement), tuser on non-last beats carries noise that must be ignored.
   task automatic send_frame(input int n, input logic [7:0] base, input logic [2:0] dest,
                             input logic err, output int stalls, output int last_cyc);
      stalls = 0;
      for (int i = 0; i < n; i++) begin
         int w;
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = bdata(base, i);
         s_axis_tkeep  = bkeep(i);
         s_axis_tlast  = (i == n - 1);
         s_axis_tuser  = (i == n - 1) ? err : ~err;
         s_axis_tdest  = (i == 0) ? dest : ~dest;
         w = 0;
         while (!s_axis_tready && w < 2000) begin
            @(negedge clk);
            stalls++;
            w++;
         end
         if (w >= 2000) begin
            chk("send_timeout", 64'(w), 64'd0);
            i = n;
         end else begin
            @(negedge clk);
         end
      end
      last_cyc      = cyc;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
   endtask

   task automatic wait_beats(input int n);
      int w;
      w = 0;
      while (cap_data.size() < n && w < 3000) begin
         @(negedge clk);
         w++;
      end
   endtask

   task automatic check_frame(input string tag, input int idx, input int n,
                              input logic [7:0] base, input logic [2:0] dest);
      if (cap_data.size() < idx + n) begin
         chk({tag, "_beats"}, 64'(cap_data.size()), 64'(idx + n));
         return;
      end
      for (int i = 0; i < n; i++) begin
         chk({tag, "_data"}, cap_data[idx+i], bdata(base, i));
         chk({tag, "_keep"}, 64'(cap_keep[idx+i]), 64'(bkeep(i)));
         chk({tag, "_user"}, 64'(cap_user[idx+i]), 64'(i == 0));
         chk({tag, "_last"}, 64'(cap_last[idx+i]), 64'(i == n - 1));
         chk({tag, "_dest"}, 64'(cap_dest[idx+i]), 64'(dest));
         chk({tag, "_contig"}, 64'(cap_cyc[idx+i] - cap_cyc[idx]), 64'(i));
      end
   endtask

   initial begin
      int st, lc, sz;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_tready", 64'(s_axis_tready), 64'd0);
      chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_avail",  64'(frame_avail), 64'd0);
`ifdef AXIS_SF_DROP_CNT_EN
      chk("rst_drop", 64'(drop_cnt), 64'd0);
`endif
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_tready", 64'(s_axis_tready), 64'd1);

      // single 4-beat frame, first beat 2 cycles after the pop
      send_frame(4, 8'h01, 3'd5, 1'b0, st, lc);
      wait_beats(4);
      repeat (4) @(negedge clk);
      chk("f4_count", 64'(cap_data.size()), 64'd4);
      check_frame("f4", 0, 4, 8'h01, 3'd5);
      if (cap_cyc.size() > 0) chk("f4_latency", 64'(cap_cyc[0] - lc), 64'd2);
      cap_clear();

      // errored frame dropped, good frame follows
      send_frame(3, 8'h02, 3'd1, 1'b1, st, lc);
      send_frame(2, 8'h03, 3'd2, 1'b0, st, lc);
      wait_beats(2);
      repeat (6) @(negedge clk);
      chk("err_count", 64'(cap_data.size()), 64'd2);
      check_frame("err_good", 0, 2, 8'h03, 3'd2);
`ifdef AXIS_SF_DROP_CNT_EN
      chk("err_drop", 64'(drop_cnt), 64'd1);
`endif
      cap_clear();

      // oversize frame swallowed without backpressure
      send_frame(300, 8'h04, 3'd3, 1'b0, st, lc);
      chk("big_stalls", 64'(st), 64'd0);
      send_frame(1, 8'h05, 3'd4, 1'b0, st, lc);
      wait_beats(1);
      repeat (6) @(negedge clk);
      chk("big_count", 64'(cap_data.size()), 64'd1);
      check_frame("big_next", 0, 1, 8'h05, 3'd4);
`ifdef AXIS_SF_DROP_CNT_EN
      chk("big_drop", 64'(drop_cnt), 64'd2);
`endif
      cap_clear();

      // bus_busy holds frames back; mid-frame busy does not stall
      bus_busy = 1'b1;
      send_frame(3, 8'h10, 3'd1, 1'b0, st, lc);
      send_frame(1, 8'h11, 3'd2, 1'b0, st, lc);
      send_frame(2, 8'h12, 3'd3, 1'b0, st, lc);
      repeat (5) @(negedge clk);
      chk("busy_avail", 64'(frame_avail), 64'd1);
      chk("busy_noout", 64'(cap_data.size()), 64'd0);
      bus_busy = 1'b0;
      wait_beats(1);
      bus_busy = 1'b1;
      repeat (10) @(negedge clk);
      chk("busy_mid_count", 64'(cap_data.size()), 64'd3);
      check_frame("busy_f0", 0, 3, 8'h10, 3'd1);
      bus_busy = 1'b0;
      wait_beats(6);
      repeat (4) @(negedge clk);
      chk("busy_count", 64'(cap_data.size()), 64'd6);
      check_frame("busy_f1", 3, 1, 8'h11, 3'd2);
      check_frame("busy_f2", 4, 2, 8'h12, 3'd3);
      if (cap_cyc.size() >= 5) chk("busy_gap", 64'(cap_cyc[4] - cap_cyc[3]), 64'd3);
      chk("busy_avail_end", 64'(frame_avail), 64'd0);
      cap_clear();

      // descriptor FIFO fill
      bus_busy = 1'b1;
      for (int f = 0; f < 16; f++) send_frame(1, 8'(8'h20 + f), 3'(f), 1'b0, st, lc);
      chk("fill_tready", 64'(s_axis_tready), 64'd0);
      chk("fill_avail", 64'(frame_avail), 64'd1);
      bus_busy = 1'b0;
      @(negedge clk);
      chk("fill_resume", 64'(s_axis_tready), 64'd1);
      send_frame(1, 8'h30, 3'd7, 1'b0, st, lc);
      wait_beats(17);
      repeat (4) @(negedge clk);
      chk("fill_count", 64'(cap_data.size()), 64'd17);
      for (int f = 0; f < 16; f++) check_frame("fill_f", f, 1, 8'(8'h20 + f), 3'(f));
      check_frame("fill_last", 16, 1, 8'h30, 3'd7);
      cap_clear();

      // reset mid-SEND
      send_frame(10, 8'h40, 3'd6, 1'b0, st, lc);
      wait_beats(3);
      chk("rs_started", 64'(cap_data.size() >= 3), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rs_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rs_tready", 64'(s_axis_tready), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sz = cap_data.size();
      @(negedge clk);
      chk("rs_avail", 64'(frame_avail), 64'd0);
      repeat (20) @(negedge clk);
      chk("rs_residual", 64'(cap_data.size()), 64'(sz));
`ifdef AXIS_SF_DROP_CNT_EN
      chk("rs_drop", 64'(drop_cnt), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
